// File: rtl/calc_disp_pkg.sv
// calc_disp_pkg: shared segment encodings, FSM states and display limit for calc_display_driver.
package calc_disp_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    function automatic int disp_max(input int digits);
        return 10 ** digits - 1;
    endfunction
    localparam int DISP_MAX = disp_max(4);
endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: one BCD digit to active-low {g,f,e,d,c,b,a} segments with blank and dash overrides.
module bcd_to_7seg
    import calc_disp_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);
    always_comb seg = blank ? SEG_BLANK : dash ? SEG_DASH : bcd > 4'd9 ? SEG_BLANK : SEG_DIGIT[bcd];
endmodule

// File: rtl/calc_display_driver.sv
// calc_display_driver: sequential binary-to-BCD (shift-and-add-3) driving four digits plus a sign digit.
// Define CALC_DISP_LZ_BLANK_EN to blank leading zeros on hex3..hex1.
module calc_display_driver
    import calc_disp_pkg::*;
#(
    parameter int WIDTH = 14,
    parameter int DIGITS = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] value,
    input  logic             sinal,
    input  logic             en,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic [6:0]       hex_sign,
    output logic             busy,
    output logic             ovf
);
    localparam int BW = 4 * DIGITS;
    localparam logic [WIDTH-1:0] LIM = WIDTH'(disp_max(DIGITS));
    state_t           state;
    logic [WIDTH+1:0] shadow;
    logic [WIDTH-1:0] bin;
    logic [BW-1:0]    bcd, adj;
    logic [CNT_W-1:0] cnt;
    logic             cap_en, cap_sign, cap_ovf;
    logic [3:0]       lz;
    logic [6:0]       seg [4];
    always_comb begin
        adj = bcd;
        for (int j = 0; j < DIGITS; j++)
            adj[4*j+:4] = bcd[4*j+:4] >= 4'd5 ? bcd[4*j+:4] + 4'd3 : bcd[4*j+:4];
    end
    always_comb begin
        lz = '0;
`ifdef CALC_DISP_LZ_BLANK_EN
        lz[3] = bcd[15:12] == 4'd0;
        lz[2] = lz[3] && bcd[11:8] == 4'd0;
        lz[1] = lz[2] && bcd[7:4] == 4'd0;
`endif
    end
    // overflow dashes win over leading-zero blanking; a disabled display wins over both
    for (genvar i = 0; i < 4; i++) begin : g_dig
        bcd_to_7seg u_seg (
            .bcd  (bcd[4*i+:4]),
            .blank(!cap_en || (!cap_ovf && lz[i])),
            .dash (cap_ovf),
            .seg  (seg[i])
        );
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shadow   <= '1;
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            cap_en   <= 1'b0;
            cap_sign <= 1'b0;
            cap_ovf  <= 1'b0;
            hex0     <= SEG_BLANK;
            hex1     <= SEG_BLANK;
            hex2     <= SEG_BLANK;
            hex3     <= SEG_BLANK;
            hex_sign <= SEG_BLANK;
            busy     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: if ({en, sinal, value} != shadow) begin
                    shadow   <= {en, sinal, value};
                    bin      <= value;
                    bcd      <= '0;
                    cnt      <= '0;
                    cap_en   <= en;
                    cap_sign <= sinal;
                    cap_ovf  <= value > LIM;
                    busy     <= 1'b1;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    {bcd, bin} <= {adj[BW-2:0], bin, 1'b0};
                    cnt        <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) state <= UPDATE;
                end
                UPDATE: begin
                    hex0     <= seg[0];
                    hex1     <= seg[1];
                    hex2     <= seg[2];
                    hex3     <= seg[3];
                    hex_sign <= cap_en && cap_sign ? SEG_DASH : SEG_BLANK;
                    ovf      <= cap_en && cap_ovf;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_display_driver.sv
// tb_calc_display_driver: table-driven scoreboard bench for calc_display_driver (honours CALC_DISP_LZ_BLANK_EN).
module tb_calc_display_driver;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [13:0] value;
    logic        sinal, en;
    logic [6:0]  hex0, hex1, hex2, hex3, hex_sign;
    logic        busy, ovf;
    typedef struct packed {
        logic [3:0][6:0] h;
        logic [6:0]      s;
        logic            o;
    } exp_t;
    typedef struct {
        logic        e;
        logic        sg;
        logic [13:0] v;
        exp_t        x;
    } vec_t;
`ifdef CALC_DISP_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DA = 7'b0111111;
    logic [6:0] dig [10];
    exp_t q[$];
    vec_t tv[13];
    int n_chk = 0, n_fail = 0, lo;

    calc_display_driver dut (
        .clk(clk), .rst_n(rst_n), .value(value), .sinal(sinal), .en(en),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex_sign(hex_sign),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic e, input logic sg, input logic [13:0] v);
        exp_t x;
        int p = 1;
        x.s = (e && sg) ? DA : BL;
        x.o = e && v > 9999;
        for (int j = 0; j < 4; j++) begin
            x.h[j] = !e ? BL : x.o ? DA : (LZ && j > 0 && int'(v) < p) ? BL : dig[(int'(v) / p) % 10];
            p *= 10;
        end
        return x;
    endfunction

    function automatic vec_t mk(input logic e, input logic sg, input logic [13:0] v);
        vec_t t;
        t.e = e; t.sg = sg; t.v = v; t.x = model(e, sg, v);
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_conv(input string nm, input int chg_at, input logic [13:0] chg_v, output int low);
        exp_t x, snap;
        int hi = 0;
        bit held = 1'b1;
        snap = {hex3, hex2, hex1, hex0, hex_sign, ovf};
        low = 0;
        @(negedge clk);
        while (!busy && low < 20) begin
            low++;
            @(negedge clk);
        end
        if (!busy) begin
            chk({nm, " start_timeout"}, 32'(busy), 32'd1);
            return;
        end
        while (busy && hi < 40) begin
            hi++;
            if ({hex3, hex2, hex1, hex0, hex_sign, ovf} !== snap) held = 1'b0;
            if (hi == chg_at) value = chg_v;
            @(negedge clk);
        end
        chk({nm, " busy_cycles"}, 32'(hi), 32'd15);
        chk({nm, " hold"}, 32'(held), 32'd1);
        if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            x = q.pop_front();
            chk({nm, " hex0"}, 32'(hex0), 32'(x.h[0]));
            chk({nm, " hex1"}, 32'(hex1), 32'(x.h[1]));
            chk({nm, " hex2"}, 32'(hex2), 32'(x.h[2]));
            chk({nm, " hex3"}, 32'(hex3), 32'(x.h[3]));
            chk({nm, " hex_sign"}, 32'(hex_sign), 32'(x.s));
            chk({nm, " ovf"}, 32'(ovf), 32'(x.o));
        end
    endtask

    task automatic run(input vec_t t, input string nm);
        int l;
        en = t.e;
        sinal = t.sg;
        value = t.v;
        q.push_back(t.x);
        wait_conv(nm, 0, 14'd0, l);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        dig = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        tv[0]  = mk(1, 0, 14'd9801);
        tv[1]  = mk(1, 1, 14'd42);
        tv[2]  = mk(1, 0, 14'd12000);
        tv[3]  = mk(1, 1, 14'd12000);
        tv[4]  = mk(1, 0, 14'd123);
        tv[5]  = mk(0, 0, 14'd123);
        tv[6]  = mk(0, 1, 14'd5);
        tv[7]  = mk(1, 0, 14'd9999);
        tv[8]  = mk(1, 1, 14'd10000);
        tv[9]  = mk(1, 0, 14'd16383);
        tv[10] = mk(1, 0, 14'd7);
        tv[11] = mk(1, 0, 14'd100);
        tv[12] = mk(1, 1, 14'd0);
        en = 1'b1;
        sinal = 1'b0;
        value = 14'd0;
        repeat (2) @(negedge clk);
        chk("reset hex0", 32'(hex0), 32'(BL));
        chk("reset hex3", 32'(hex3), 32'(BL));
        chk("reset hex_sign", 32'(hex_sign), 32'(BL));
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset ovf", 32'(ovf), 32'd0);
        q.push_back(model(1, 0, 14'd0));
        rst_n = 1'b1;
        wait_conv("reset_zero", 0, 14'd0, lo);
        for (int i = 0; i < 13; i++) run(tv[i], $sformatf("vec%0d", i));
        en = 1'b1;
        sinal = 1'b0;
        value = 14'd99;
        q.push_back(model(1, 0, 14'd99));
        q.push_back(model(1, 0, 14'd45));
        wait_conv("b2b_99", 5, 14'd45, lo);
        wait_conv("b2b_45", 0, 14'd0, lo);
        chk("b2b extra_idle_cycles", 32'(lo), 32'd0);
        value = 14'd777;
        repeat (4) @(negedge clk);
        chk("midreset busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset hex0", 32'(hex0), 32'(BL));
        chk("midreset hex1", 32'(hex1), 32'(BL));
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back(model(1, 0, 14'd777));
        wait_conv("post_reset", 0, 14'd0, lo);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/calc_display_driver.md
Name: calc_display_driver

Overview:
- Downstream stage of the calculator core. Consumes the 14-bit result, the sign flag and the enable flag, and drives five 7-segment displays: four magnitude digits plus one sign digit.
- Converts binary to BCD sequentially with shift-and-add-3, one bit per clock, then encodes each digit to active-low segments.
- Display registers update atomically, so digits never show a half-converted value.

Parameters:
- WIDTH, 14, input magnitude width.
- DIGITS, 4, number of BCD magnitude digits; max displayable value is 10^DIGITS-1.
- CNT_W, 4, width of the shift counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- value  in  WIDTH  binary magnitude from the calculator result.
- sinal  in  1  1 = negative result.
- en  in  1  1 = calculator on; 0 = display blank.
- hex0  out  7  units digit segments {g,f,e,d,c,b,a}, active-low.
- hex1  out  7  tens digit segments.
- hex2  out  7  hundreds digit segments.
- hex3  out  7  thousands digit segments.
- hex_sign  out  7  sign digit segments.
- busy  out  1  conversion in progress.
- ovf  out  1  displayed value exceeds 10^DIGITS-1.

Behaviour:
- Reset (async, rst_n=0):
  - hex0..hex3 and hex_sign = 7'b1111111 (blank).
  - busy=0, ovf=0, FSM=IDLE.
  - Shadow register {en,sinal,value} = all-ones, which forces a conversion after reset release.
- FSM states IDLE, SHIFT, UPDATE.
- IDLE:
  - If {en,sinal,value} != shadow: capture the inputs into shadow and working registers, clear the BCD accumulator, set counter=0, busy=1, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - Each cycle, every BCD nibble >=5 gets +3, then {bcd,bin} shifts left by 1 and counter increments.
  - After WIDTH shifts (counter==WIDTH-1 on that edge), go to UPDATE.
- UPDATE (one cycle): load output registers from the BCD digits and captured flags; busy=0; go to IDLE.
- Latency: input captured on edge k; outputs change on edge k+WIDTH+1 (edge k+15 by default). busy is high for WIDTH+1 cycles.
- Input changes during SHIFT or UPDATE are ignored. They are detected in IDLE on the next cycle and trigger a new conversion. Back-to-back conversions therefore start every WIDTH+2 cycles minimum.
- Overflow:
  - ovf is evaluated at capture as value > 10^DIGITS-1 and registered at UPDATE.
  - When ovf=1, all magnitude digits show a dash (7'b0111111) instead of BCD.
- Output mapping at UPDATE:
  - en=0 (captured): all five outputs blank and ovf=0.
  - en=1: digits are encoded with digit patterns 0..9 (0=1000000, 1=1111001, ... 9=0010000).
  - en=1, sinal=1: hex_sign = dash; otherwise hex_sign = blank.
- Reset mid-conversion: immediate return to reset values. The pending conversion is discarded and restarts after release.

Optional Feature:
- Macro CALC_DISP_LZ_BLANK_EN.
- Defined: leading-zero blanking. Blank a magnitude digit when it and every more-significant digit are zero. hex0 is never blanked, so value 0 shows a single "0". When the leading-zero suppression leaves digits blank, the sign dash stays on hex_sign (fixed position).
- Undefined: all four digits are always shown with leading zeros ("0042").

Decomposition:
- Shared package calc_disp_pkg:
  - Segment constants SEG_BLANK, SEG_DASH and the SEG_DIGIT[0:9] array.
  - FSM state enum.
  - DISP_MAX = 10^DIGITS-1.
- Sub-module bcd_to_7seg: combinational, 4-bit BCD plus blank and dash controls in, 7-bit active-low segments out. Instantiated once per digit.

Test Plan:
- Reset then release with en=1, value=0, sinal=0: busy is high for 15 cycles. Then hex0=1000000 and hex3..hex1 = blank (macro on) or 1000000 (macro off), hex_sign=1111111.
- value=9801, en=1: 15 cycles after capture, hex3=0010000, hex2=0000000, hex1=1000000, hex0=1111001, ovf=0. Outputs hold their previous values until that edge.
- value=42, sinal=1: hex_sign=0111111, hex1=0011001, hex0=0100100. With the macro on, hex3 and hex2 are blank.
- value=12000 (exceeds 9999): ovf=1 and all hex0..hex3=0111111.
- Change value 99→45 at cycle 5 of a conversion of 99: outputs first show 99, then a second conversion completes and shows 45. busy is low for exactly one cycle between the two conversions.
- en 1→0 while value=123: after 15 cycles all outputs are 1111111 and ovf=0. Asserting rst_n=0 mid-conversion blanks the outputs immediately and clears busy.
